// File: rtl/pkt_sort_pkg.sv
// rtl/pkt_sort_pkg.sv - shared sort direction encodings and element-width helper
package pkt_sort_pkg;

   localparam logic DIR_ASC  = 1'b0;
   localparam logic DIR_DESC = 1'b1;

   function automatic int elem_width(input int key_width, input int payload_width);
      return key_width + payload_width;
   endfunction

endpackage

// File: rtl/bitonic_cmp_swap.sv
// rtl/bitonic_cmp_swap.sv - combinational key compare-exchange cell, payload rides along
module bitonic_cmp_swap
   import pkt_sort_pkg::*;
#(
   parameter int KEY_WIDTH     = 8,
   parameter int PAYLOAD_WIDTH = 8,
   parameter int EW            = elem_width(KEY_WIDTH, PAYLOAD_WIDTH)
) (
   input  logic [EW-1:0] a,
   input  logic [EW-1:0] b,
   input  logic          dir,
   output logic [EW-1:0] lo,
   output logic [EW-1:0] hi
);

   logic [KEY_WIDTH-1:0] key_a;
   logic [KEY_WIDTH-1:0] key_b;
   logic                 swap;

   assign key_a = a[EW-1 -: KEY_WIDTH];
   assign key_b = b[EW-1 -: KEY_WIDTH];

   // strict compares so equal keys never move
   always_comb begin
      swap = 1'b0;
      if (dir == DIR_ASC) swap = (key_a > key_b);
      else                swap = (key_a < key_b);
   end

   assign lo = swap ? b : a;
   assign hi = swap ? a : b;

endmodule

// File: rtl/bitonic_merge_kv.sv
// rtl/bitonic_merge_kv.sv - pipelined key/payload bitonic merger with per-vector direction
module bitonic_merge_kv
   import pkt_sort_pkg::*;
#(
   parameter int N             = 16,
   parameter int LOG_N         = 4,
   parameter int KEY_WIDTH     = 8,
   parameter int PAYLOAD_WIDTH = 8
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic                                   in_dir,
   input  logic [N*(KEY_WIDTH+PAYLOAD_WIDTH)-1:0] in_data,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic                                   out_dir,
   output logic [N*(KEY_WIDTH+PAYLOAD_WIDTH)-1:0] out_data
);

   localparam int EW = elem_width(KEY_WIDTH, PAYLOAD_WIDTH);
   localparam int DW = N * EW;

   // element 0 sits in the most significant EW bits of each data word
   logic [DW-1:0]  st_data [LOG_N+1];
   logic [LOG_N:0] st_valid;
   logic [LOG_N:0] st_dir;
   logic [DW-1:0]  cx      [LOG_N];
   logic           en;

   assign en       = !st_valid[LOG_N] || out_ready;
   assign in_ready = en;

   for (genvar s = 0; s < LOG_N; s++) begin : g_stage
      localparam int D = N >> (s + 1);
      for (genvar p = 0; p < N/2; p++) begin : g_cell
         localparam int X = (p / D) * 2 * D + (p % D);
         localparam int Y = X + D;
         bitonic_cmp_swap #(
            .KEY_WIDTH     (KEY_WIDTH),
            .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
            .EW            (EW)
         ) u_cell (
            .a   (st_data[s][(N-1-X)*EW +: EW]),
            .b   (st_data[s][(N-1-Y)*EW +: EW]),
            .dir (st_dir[s]),
            .lo  (cx[s][(N-1-X)*EW +: EW]),
            .hi  (cx[s][(N-1-Y)*EW +: EW])
         );
      end
   end

   // one shared enable: the whole pipe freezes while the output is back-pressured
   always_ff @(posedge clk) begin
      if (reset) begin
         st_valid <= '0;
         st_dir   <= '0;
         for (int s = 0; s <= LOG_N; s++) st_data[s] <= '0;
      end else if (en) begin
         st_valid   <= {st_valid[LOG_N-1:0], in_valid};
         st_dir     <= {st_dir[LOG_N-1:0], in_dir};
         st_data[0] <= in_data;
         for (int s = 0; s < LOG_N; s++) st_data[s+1] <= cx[s];
      end
   end

   assign out_valid = st_valid[LOG_N];
   assign out_dir   = st_dir[LOG_N];
   assign out_data  = st_valid[LOG_N] ? st_data[LOG_N] : '0;

endmodule

// File: tb/tb_bitonic_merge_kv.sv
// tb/tb_bitonic_merge_kv.sv - self-checking bench for bitonic_merge_kv (N=8, 4-bit key, 4-bit payload)
module tb_bitonic_merge_kv;

   localparam int N     = 8;
   localparam int LOG_N = 3;
   localparam int KW    = 4;
   localparam int PW    = 4;
   localparam int EW    = KW + PW;
   localparam int DW    = N * EW;

   localparam logic [DW-1:0] LIT_ASC  = 64'h07102631_45526473;
   localparam logic [DW-1:0] LIT_DESC = 64'h73645245_31261007;
   localparam logic [DW-1:0] LIT_DUP  = 64'h20212627_54555253;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic          in_dir;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_dir;
   logic [DW-1:0] out_data;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_out    = 0;
   bit cur_bitonic = 1'b1;
   bit lat_mode    = 1'b1;

   typedef struct {
      logic [DW-1:0] data;
      logic          dir;
      bit            bitonic;
      bit            lat;
      int            acc;
   } exp_t;
   exp_t exp_q[$];

   int ka[N]   = '{1, 3, 5, 7, 6, 4, 2, 0};
   int kc[N]   = '{2, 2, 5, 5, 5, 5, 2, 2};
   int kd[N]   = '{3, 1, 4, 1, 5, 9, 2, 6};
   int pidx[N] = '{0, 1, 2, 3, 4, 5, 6, 7};

   bitonic_merge_kv #(
      .N             (N),
      .LOG_N         (LOG_N),
      .KEY_WIDTH     (KW),
      .PAYLOAD_WIDTH (PW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_dir    (in_dir),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dir   (out_dir),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [DW-1:0] mkvec(input int k[N], input int p[N]);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[(N-1-i)*EW +: EW] = {KW'(k[i]), PW'(p[i])};
      return r;
   endfunction

   function automatic logic [EW-1:0] elem(input logic [DW-1:0] d, input int i);
      return d[(N-1-i)*EW +: EW];
   endfunction

   // multiset fingerprint: elements sorted by full value
   function automatic logic [DW-1:0] sort_elems(input logic [DW-1:0] d);
      int e[N];
      int t;
      logic [DW-1:0] r;
      for (int i = 0; i < N; i++) e[i] = int'(elem(d, i));
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N-1-i; j++)
            if (e[j] > e[j+1]) begin t = e[j]; e[j] = e[j+1]; e[j+1] = t; end
      r = '0;
      for (int i = 0; i < N; i++) r[(N-1-i)*EW +: EW] = EW'(e[i]);
      return r;
   endfunction

   function automatic logic [N*KW-1:0] keys_of(input logic [DW-1:0] d);
      logic [N*KW-1:0] r;
      logic [EW-1:0] e;
      for (int i = 0; i < N; i++) begin
         e = elem(d, i);
         r[(N-1-i)*KW +: KW] = e[EW-1 -: KW];
      end
      return r;
   endfunction

   function automatic logic [N*KW-1:0] exp_keys(input logic [DW-1:0] d, input logic dir);
      int k[N];
      int t;
      logic [EW-1:0] e;
      logic [N*KW-1:0] r;
      for (int i = 0; i < N; i++) begin
         e = elem(d, i);
         k[i] = int'(e[EW-1 -: KW]);
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N-1-i; j++)
            if (k[j] > k[j+1]) begin t = k[j]; k[j] = k[j+1]; k[j+1] = t; end
      for (int i = 0; i < N; i++) r[(N-1-i)*KW +: KW] = KW'(dir ? k[N-1-i] : k[i]);
      return r;
   endfunction

   // compare process: protocol rules every cycle, model check on every emitted vector
   initial begin : cmp
      bit            stalled;
      logic [DW-1:0] prev_data;
      logic          prev_dir;
      exp_t          e;
      stalled = 1'b0;
      prev_data = '0;
      prev_dir = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            stalled = 1'b0;
         end else begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (!out_valid) chk("out_data_gated", out_data, '0);
            if (stalled) begin
               chk("stall_valid", out_valid, 1'b1);
               chk("stall_data", out_data, prev_data);
               chk("stall_dir", out_dir, prev_dir);
            end
            if (out_valid && out_ready) begin
               n_out++;
               if (exp_q.size() == 0) begin
                  chk("spurious_out", out_data, '0);
                  chk("spurious_valid", out_valid, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  chk("model_dir", out_dir, e.dir);
                  chk("model_perm", sort_elems(out_data), sort_elems(e.data));
                  if (e.bitonic) chk("model_keys", keys_of(out_data), exp_keys(e.data, e.dir));
                  if (e.lat) chk("model_latency", cyc - e.acc, LOG_N + 1);
               end
            end
            if (in_valid && in_ready)
               exp_q.push_back('{data: in_data, dir: in_dir, bitonic: cur_bitonic,
                                 lat: lat_mode, acc: cyc});
            stalled   = out_valid && !out_ready;
            prev_data = out_data;
            prev_dir  = out_dir;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic dir, input bit bito, output int acc);
      in_valid    = 1'b1;
      in_data     = d;
      in_dir      = dir;
      cur_bitonic = bito;
      acc         = -1;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (in_ready && !reset) begin
            acc = cyc;
            step();
            return;
         end
         step();
      end
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted (cycle %0d)", cyc);
   endtask

   task automatic wait_out(input int acc, input string nm);
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (out_valid) begin
            chk(nm, cyc - acc, LOG_N + 1);
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=out_valid (cycle %0d)", nm, cyc);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int a1, a2, a3;
      bit done;
      int k[N], s[N], p[N];
      int t;

      reset     = 1'b1;
      in_valid  = 1'b1;
      in_dir    = 1'b1;
      in_data   = {DW{1'b1}};
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk("rst_out_dir", out_dir, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      repeat (LOG_N + 3) begin
         @(negedge clk);
         chk("no_accept_during_reset", out_valid, 1'b0);
      end

      step();
      send(mkvec(ka, pidx), 1'b0, 1'b1, a1);
      in_valid = 1'b0;
      wait_out(a1, "lat_asc");
      chk("asc_literal", out_data, LIT_ASC);
      chk("asc_dir", out_dir, 1'b0);

      step();
      send(mkvec(ka, pidx), 1'b1, 1'b1, a1);
      send(mkvec(ka, pidx), 1'b0, 1'b1, a2);
      in_valid = 1'b0;
      wait_out(a1, "lat_desc");
      chk("desc_literal", out_data, LIT_DESC);
      chk("desc_dir", out_dir, 1'b1);
      @(negedge clk);
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_literal", out_data, LIT_ASC);
      chk("b2b_dir", out_dir, 1'b0);

      step();
      send(mkvec(kc, pidx), 1'b0, 1'b1, a1);
      in_valid = 1'b0;
      wait_out(a1, "lat_dup");
      chk("dup_literal", out_data, LIT_DUP);

      step();
      lat_mode = 1'b0;
      send(mkvec(ka, pidx), 1'b0, 1'b1, a1);
      send(mkvec(kc, pidx), 1'b0, 1'b1, a2);
      send(mkvec(ka, pidx), 1'b1, 1'b1, a3);
      in_valid  = 1'b0;
      lat_mode  = 1'b1;
      out_ready = 1'b0;
      wait_out(a1, "lat_stall_head");
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_head_literal", out_data, LIT_ASC);
      end
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("release_consecutive", out_valid, 1'b1);
      end
      @(negedge clk);
      chk("release_drained", out_valid, 1'b0);

      step();
      send(mkvec(kd, pidx), 1'b1, 1'b0, a1);
      in_valid = 1'b0;
      wait_out(a1, "lat_nonbitonic");

      step();
      lat_mode = 1'b0;
      done = 1'b0;
      fork
         begin
            for (int v = 0; v < 12; v++) begin
               for (int i = 0; i < N; i++) begin
                  s[i] = $urandom_range(0, 15);
                  p[i] = $urandom_range(0, 15);
               end
               for (int i = 0; i < N; i++)
                  for (int j = 0; j < N-1-i; j++)
                     if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
               for (int i = 0; i < N/2; i++) begin
                  k[i]     = s[2*i];
                  k[N-1-i] = s[2*i+1];
               end
               send(mkvec(k, p), 1'($urandom_range(0, 1)), 1'b1, a1);
            end
            in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               step();
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      lat_mode  = 1'b1;
      repeat (LOG_N + 4) @(negedge clk);

      step();
      send(mkvec(ka, pidx), 1'b0, 1'b1, a1);
      in_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < LOG_N + 2; i++) begin
         @(negedge clk);
         chk("flushed_no_out", out_valid, 1'b0);
      end
      step();
      send(mkvec(ka, pidx), 1'b0, 1'b1, a1);
      in_valid = 1'b0;
      wait_out(a1, "lat_post_reset");
      chk("post_reset_literal", out_data, LIT_ASC);

      repeat (LOG_N + 4) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      chk("emit_count", n_out, 21);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
